mod3_stream_acc: RTL

Streaming divisibility-by-3 accumulator: consumes an arbitrary-length unsigned number as a packet of DATA_W-bit words, most-significant word first, over a valid/ready handshake. It reports the remainder mod 3, a divisible flag and the packet word count. It sits upstream of the word-level divisibility checks and extends them from a single word to multi-word operands. It keeps a running residue instead of wide arithmetic.

---
 rtl/mod3_stream_acc.sv | 102 ++++++++++
 1 files changed

// File: rtl/mod3_stream_acc.sv
// rtl/mod3_stream_acc.sv - streaming divisibility-by-3 accumulator over multi-word packets
module mod3_stream_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_rem,
    output logic              out_div,
    output logic [15:0]       out_words
);

    typedef enum logic {ACC, HOLD} state_t;

    // Weight of one whole word position: 2^DATA_W mod 3.
    localparam logic [1:0] K = (DATA_W % 2 == 0) ? 2'd1 : 2'd2;

    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Bit i carries weight 2^i mod 3, which alternates 1, 2, 1, 2, ...
    function automatic logic [1:0] word_mod3(input logic [DATA_W-1:0] d);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 0; i < DATA_W; i++) begin
            if (d[i]) begin
                res = add_mod3(res, (i % 2 == 0) ? 2'd1 : 2'd2);
            end
        end
        return res;
    endfunction

    state_t      state;
    logic [1:0]  r;
    logic [15:0] cnt;
    logic [1:0]  w;
    logic [1:0]  r_scaled;
    logic [1:0]  r_next;
    logic [15:0] cnt_next;
    logic        accept;

    assign in_ready = (state == ACC);
    assign accept   = in_valid && in_ready;

    always_comb begin
        w        = word_mod3(in_data);
        r_scaled = (K == 2'd1) ? r : add_mod3(r, r);
        r_next   = add_mod3(r_scaled, w);
        cnt_next = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            r         <= 2'd0;
            cnt       <= 16'd0;
            out_valid <= 1'b0;
            out_rem   <= 2'd0;
            out_div   <= 1'b0;
            out_words <= 16'd0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            out_rem   <= r_next;
                            out_div   <= (r_next == 2'd0);
                            out_words <= cnt_next;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            r   <= r_next;
                            cnt <= cnt_next;
                        end
                    end
                end
                HOLD: begin
                    // Result fields are left as-is after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r         <= 2'd0;
                        cnt       <= 16'd0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
